// File: rtl/modadd_rr_sched.sv
// Round-robin scheduler feeding one shared combinational modular adder.
// Two registered stages: operand/tag capture (S1) and a back-pressured response (S2).
module modadd_rr_sched #(
   parameter int unsigned       DATA_W = 64,
   parameter logic [DATA_W-1:0] M      = 64'hffff_ffff_0000_0001,
   parameter int unsigned       N_REQ  = 4,
   localparam int unsigned      ID_W   = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ-1:0]        req_sub,
   input  logic [N_REQ*DATA_W-1:0] req_x,
   input  logic [N_REQ*DATA_W-1:0] req_y,
   output logic [N_REQ-1:0]        req_ready,
   output logic [DATA_W-1:0]       add_x,
   output logic [DATA_W-1:0]       add_y,
   input  logic [DATA_W-1:0]       add_z,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_W-1:0]       rsp_data,
   output logic [ID_W-1:0]         rsp_id,
   output logic [31:0]             op_cnt
);

   logic              s1_valid_q, s1_valid_d;
   logic [DATA_W-1:0] add_x_q, add_x_d, add_y_q, add_y_d;
   logic [ID_W-1:0]   s1_id_q, s1_id_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic [31:0]       op_cnt_q, op_cnt_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;

   logic [DATA_W-1:0] lane_x [N_REQ];
   logic [DATA_W-1:0] lane_y [N_REQ];

   logic              s2_adv, s1_adv, accept;
   logic              grant_vld;
   logic [ID_W-1:0]   grant_idx, scan_idx;
   logic [N_REQ-1:0]  grant_oh;
   logic [DATA_W-1:0] x_sel, y_sel, y_eff;

   for (genvar g = 0; g < N_REQ; g++) begin : g_lane
      assign lane_x[g] = req_x[g*DATA_W +: DATA_W];
      assign lane_y[g] = req_y[g*DATA_W +: DATA_W];
   end

   assign s2_adv = ~rsp_valid_q | rsp_ready;
   assign s1_adv = ~s1_valid_q | s2_adv;

   // Scan starts just past the last winner so the previous grantee has lowest priority.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      scan_idx  = '0;
      grant_oh  = '0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         scan_idx = ID_W'((32'(ptr_q) + k) % N_REQ);
         if (!grant_vld && req_valid[scan_idx]) begin
            grant_vld = 1'b1;
            grant_idx = scan_idx;
         end
      end
      if (grant_vld) grant_oh[grant_idx] = 1'b1;
   end

   assign req_ready = grant_oh & {N_REQ{s1_adv}};
   assign accept    = grant_vld & s1_adv;
   assign x_sel     = lane_x[grant_idx];
   assign y_sel     = lane_y[grant_idx];
   assign y_eff     = req_sub[grant_idx] ? ((y_sel == '0) ? '0 : M - y_sel) : y_sel;

   always_comb begin
      s1_valid_d  = s1_valid_q;
      add_x_d     = add_x_q;
      add_y_d     = add_y_q;
      s1_id_d     = s1_id_q;
      ptr_d       = ptr_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_id_d    = rsp_id_q;
      op_cnt_d    = op_cnt_q + {31'd0, rsp_valid_q & rsp_ready};
      if (s1_adv) s1_valid_d = accept;
      if (accept) begin
         add_x_d = x_sel;
         add_y_d = y_eff;
         s1_id_d = grant_idx;
         ptr_d   = grant_idx;
      end
      if (s2_adv) begin
         rsp_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            rsp_data_d = add_z;
            rsp_id_d   = s1_id_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         add_x_q     <= '0;
         add_y_q     <= '0;
         s1_id_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
         op_cnt_q    <= '0;
         ptr_q       <= ID_W'(N_REQ - 1);
      end else begin
         s1_valid_q  <= s1_valid_d;
         add_x_q     <= add_x_d;
         add_y_q     <= add_y_d;
         s1_id_q     <= s1_id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_id_q    <= rsp_id_d;
         op_cnt_q    <= op_cnt_d;
         ptr_q       <= ptr_d;
      end
   end

   assign add_x     = add_x_q;
   assign add_y     = add_y_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
   assign op_cnt    = op_cnt_q;

endmodule

// File: tb/tb_modadd_rr_sched.sv
// Bench for modadd_rr_sched: models the shared adder and predicts grants and
// responses from round-robin and modular-arithmetic rules with an in-order queue.
module tb_modadd_rr_sched;
   localparam int unsigned W = 64;
   localparam int unsigned N = 4;
   localparam logic [63:0] MOD = 64'hffff_ffff_0000_0001;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  req_valid, req_sub, req_ready;
   logic [N*W-1:0] req_x, req_y;
   logic [W-1:0]  add_x, add_y, add_z, rsp_data;
   logic          rsp_valid, rsp_ready;
   logic [1:0]    rsp_id;
   logic [31:0]   op_cnt;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [63:0] data;
      int          id;
      bit          in_s2;
   } op_t;
   op_t         pipe[$];
   int          m_ptr;
   logic [31:0] m_cnt;

   always #5 clk = ~clk;

   function automatic logic [63:0] mod_add(input logic [63:0] a, input logic [63:0] b);
      logic [64:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, MOD}) s = s - {1'b0, MOD};
      return s[63:0];
   endfunction

   // Attached shared adder.
   assign add_z = mod_add(add_x, add_y);

   function automatic logic [63:0] ref_op(input bit sub, input logic [63:0] x, input logic [63:0] y);
      if (!sub) return mod_add(x, y);
      if (x >= y) return x - y;
      return x + (MOD - y);
   endfunction

   function automatic logic [63:0] rand_op();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r % MOD;
   endfunction

   modadd_rr_sched #(.DATA_W(W), .M(MOD), .N_REQ(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_sub(req_sub), .req_x(req_x), .req_y(req_y),
      .req_ready(req_ready), .add_x(add_x), .add_y(add_y), .add_z(add_z),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_id(rsp_id), .op_cnt(op_cnt)
   );

   task automatic set_lane(input int i, input bit sub, input logic [63:0] x, input logic [63:0] y);
      req_sub[i]        = sub;
      req_x[i*W +: W]   = x;
      req_y[i*W +: W]   = y;
   endtask

   task automatic rand_lanes();
      for (int i = 0; i < N; i++) set_lane(i, 1'($urandom), rand_op(), rand_op());
   endtask

   task automatic model_reset();
      pipe.delete();
      m_ptr = N - 1;
      m_cnt = '0;
   endtask

   // One clock: check outputs against the model, then advance the model past the edge.
   task automatic cycle();
      int g;
      bit acc, pres, s2_adv;
      logic [N-1:0] exp_rdy;
      op_t o;
      #1;
      g = -1;
      for (int k = 1; k <= N; k++)
         if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      pres = (pipe.size() > 0) && pipe[0].in_s2;
      acc  = (g >= 0) && !(pipe.size() == 2 && !rsp_ready);
      exp_rdy = '0;
      if (acc) exp_rdy[g] = 1'b1;
      n_vec++;
      if (req_ready !== exp_rdy) begin
         n_err++;
         $display("FAIL req_ready: got %b expected %b", req_ready, exp_rdy);
      end
      n_vec++;
      if (rsp_valid !== pres) begin
         n_err++;
         $display("FAIL rsp_valid: got %b expected %b", rsp_valid, pres);
      end
      if (pres) begin
         n_vec++;
         if (rsp_data !== pipe[0].data || rsp_id !== 2'(pipe[0].id)) begin
            n_err++;
            $display("FAIL rsp_data/id: got %h/%0d expected %h/%0d",
                     rsp_data, rsp_id, pipe[0].data, pipe[0].id);
         end
      end
      n_vec++;
      if (op_cnt !== m_cnt) begin
         n_err++;
         $display("FAIL op_cnt: got %0d expected %0d", op_cnt, m_cnt);
      end
      if (acc) begin
         o.data  = ref_op(req_sub[g], req_x[g*W +: W], req_y[g*W +: W]);
         o.id    = g;
         o.in_s2 = 1'b0;
      end
      @(posedge clk);
      #1;
      s2_adv = !pres || rsp_ready;
      if (pres && rsp_ready) m_cnt = m_cnt + 1;
      if (s2_adv) begin
         if (pres) void'(pipe.pop_front());
         if (pipe.size() > 0) pipe[0].in_s2 = 1'b1;
      end
      if (acc) begin
         pipe.push_back(o);
         m_ptr = g;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      n_vec++;
      if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== '0 || op_cnt !== '0 ||
          add_x !== '0 || add_y !== '0) begin
         n_err++;
         $display("FAIL %s: got v=%b d=%h id=%0d cnt=%0d ax=%h ay=%h expected all zero",
                  tag, rsp_valid, rsp_data, rsp_id, op_cnt, add_x, add_y);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = '0; req_sub = '0; req_x = '0; req_y = '0; rsp_ready = 1'b1;
      #3;
      check_reset_outputs("reset_state");
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_single_add();
      set_lane(0, 1'b0, MOD - 64'd1, 64'd2);
      req_valid = 4'b0001;
      cycle();
      req_valid = '0;
      cycle();
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_data !== 64'd1 || rsp_id !== 2'd0) begin
         n_err++;
         $display("FAIL single_add: got v=%b d=%h id=%0d expected v=1 d=1 id=0",
                  rsp_valid, rsp_data, rsp_id);
      end
      repeat (2) cycle();
   endtask

   task automatic test_sub();
      set_lane(2, 1'b1, 64'd3, 64'd5);
      req_valid = 4'b0100;
      cycle();
      set_lane(2, 1'b1, 64'd7, 64'd0);
      cycle();
      req_valid = '0;
      n_vec++;
      if (rsp_data !== MOD - 64'd2 || rsp_id !== 2'd2) begin
         n_err++;
         $display("FAIL sub_neg: got %h id %0d expected %h id 2", rsp_data, rsp_id, MOD - 64'd2);
      end
      cycle();
      n_vec++;
      if (rsp_data !== 64'd7) begin
         n_err++;
         $display("FAIL sub_y0: got %h expected 7", rsp_data);
      end
      repeat (2) cycle();
   endtask

   task automatic test_all_lanes();
      logic [31:0] start;
      start = op_cnt;
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rand_lanes();
         cycle();
      end
      req_valid = '0;
      repeat (3) cycle();
      n_vec++;
      if (op_cnt - start !== 32'd8) begin
         n_err++;
         $display("FAIL all_lanes_cnt: got %0d expected 8", op_cnt - start);
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] sx, sy;
      rsp_ready = 1'b0;
      req_valid = 4'b1111;
      rand_lanes();
      repeat (3) cycle();
      sx = add_x; sy = add_y;
      for (int i = 0; i < 3; i++) begin
         rand_lanes();
         cycle();
         n_vec++;
         if (add_x !== sx || add_y !== sy || req_ready !== '0) begin
            n_err++;
            $display("FAIL stall_hold: got ax=%h ay=%h rdy=%b expected ax=%h ay=%h rdy=0",
                     add_x, add_y, req_ready, sx, sy);
         end
      end
      rsp_ready = 1'b1;
      req_valid = '0;
      repeat (4) cycle();
   endtask

   task automatic test_sparse();
      rand_lanes();
      req_valid = 4'b1010;
      cycle();
      req_valid = 4'b1000;
      repeat (3) cycle();
      req_valid = '0;
      repeat (3) cycle();
      req_valid = 4'b1010;
      cycle();
      req_valid = '0;
      repeat (3) cycle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         rand_lanes();
         req_valid = 4'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (4) cycle();
   endtask

   task automatic test_reset_mid();
      rsp_ready = 1'b0;
      req_valid = 4'b1111;
      rand_lanes();
      repeat (3) cycle();
      req_valid = '0;
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("reset_mid");
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      rsp_ready = 1'b1;
      repeat (3) cycle();
      rand_lanes();
      req_valid = 4'b1100;
      cycle();
      req_valid = '0;
      repeat (3) cycle();
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_sub();
      test_all_lanes();
      test_backpressure();
      test_sparse();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
